ddr3_port_arbiter: RTL

- Multi-port front end for the DDR3 controller's CPU-side request path.
- Accepts read and write requests from NUM_PORTS CPU agents and picks one by round-robin.
- Issues the chosen request to the controller, keeps one transaction outstanding, and returns the completion to the granting port.
- Generalises the single-CPU hookup to N masters, adds a response timeout with error reporting, and adds optional per-port grant statistics.

---
 rtl/ddr3_arb_pkg.sv | 26 ++
 rtl/ddr3_rr_arbiter.sv | 35 +++
 rtl/ddr3_port_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/ddr3_arb_pkg.sv
// Shared types and constants for the DDR3 CPU-port arbiter.
// Optional grant statistics are enabled with DDR3_ARB_PERF_CNT_EN.
package ddr3_arb_pkg;

   localparam int ARB_ADDR_W = 27;
   localparam int ARB_DATA_W = 64;
   localparam int PERF_CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_RSP
   } arb_state_e;

   // Sized for the widest port; narrower instances zero-extend.
   typedef struct packed {
      logic                  we;
      logic [ARB_ADDR_W-1:0] addr;
      logic [ARB_DATA_W-1:0] wdata;
   } arb_req_t;

   function automatic int port_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ddr3_rr_arbiter.sv
// Combinational round-robin picker: first requester after i_last,
// wrapping modulo N.
module ddr3_rr_arbiter
   import ddr3_arb_pkg::*;
#(
   parameter int N = 4,
   parameter int W = port_w(N)
) (
   input  logic [N-1:0] i_req,
   input  logic [W-1:0] i_last,
   output logic [N-1:0] o_grant,
   output logic [W-1:0] o_grant_idx,
   output logic         o_any_req
);

   logic found;
   int   idx;

   always_comb begin
      o_grant     = '0;
      o_grant_idx = '0;
      found       = 1'b0;
      idx         = 0;
      for (int i = 1; i <= N; i++) begin
         idx = (int'(i_last) + i) % N;
         if (!found && i_req[idx]) begin
            found        = 1'b1;
            o_grant[idx] = 1'b1;
            o_grant_idx  = W'(idx);
         end
      end
      o_any_req = found;
   end

endmodule

// File: rtl/ddr3_port_arbiter.sv
// N-port round-robin front end for the DDR3 controller request path.
// Define DDR3_ARB_PERF_CNT_EN to add per-port grant counters.
module ddr3_port_arbiter
   import ddr3_arb_pkg::*;
#(
   parameter int NUM_PORTS = 4,
   parameter int ADDR_W    = ARB_ADDR_W,
   parameter int DATA_W    = ARB_DATA_W,
   parameter int TIMEOUT   = 1023
) (
   input  logic                                i_cpu_ck,
   input  logic                                i_cpu_rst_n,
   input  logic [NUM_PORTS-1:0]                i_req_valid,
   output logic [NUM_PORTS-1:0]                o_req_ready,
   input  logic [NUM_PORTS-1:0]                i_req_we,
   input  logic [NUM_PORTS-1:0][ADDR_W-1:0]    i_req_addr,
   input  logic [NUM_PORTS-1:0][DATA_W-1:0]    i_req_wdata,
   output logic [NUM_PORTS-1:0]                o_rsp_valid,
   output logic                                o_rsp_err,
   output logic [DATA_W-1:0]                   o_rsp_rdata,
   output logic                                o_ctl_valid,
   input  logic                                i_ctl_ready,
   output logic                                o_ctl_we,
   output logic [ADDR_W-1:0]                   o_ctl_addr,
   output logic [DATA_W-1:0]                   o_ctl_wdata,
   input  logic                                i_ctl_rdata_valid,
   input  logic [DATA_W-1:0]                   i_ctl_rdata,
`ifdef DDR3_ARB_PERF_CNT_EN
   output logic [NUM_PORTS-1:0][PERF_CNT_W-1:0] o_grant_cnt,
`endif
   input  logic                                i_ctl_wr_done
);

   localparam int PORT_W = port_w(NUM_PORTS);
   localparam int CNT_W  = $clog2(TIMEOUT + 1);

   arb_state_e           state_q, state_d;
   logic [PORT_W-1:0]    last_q, last_d;
   logic [PORT_W-1:0]    owner_q, owner_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   arb_req_t             ctl_q, ctl_d;
   logic [NUM_PORTS-1:0] rsp_valid_q, rsp_valid_d;
   logic                 rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;

   logic [NUM_PORTS-1:0] grant;
   logic [PORT_W-1:0]    grant_idx;
   logic                 any_req;
   logic                 rd_done;
   logic                 wr_done;

   ddr3_rr_arbiter #(
      .N (NUM_PORTS),
      .W (PORT_W)
   ) u_rr (
      .i_req       (i_req_valid),
      .i_last      (last_q),
      .o_grant     (grant),
      .o_grant_idx (grant_idx),
      .o_any_req   (any_req)
   );

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      owner_d     = owner_q;
      cnt_d       = cnt_q;
      ctl_d       = ctl_q;
      rsp_valid_d = '0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = '0;
      o_req_ready = '0;
      // Completions of the wrong type are dropped here.
      rd_done     = i_ctl_rdata_valid && !ctl_q.we;
      wr_done     = i_ctl_wr_done && ctl_q.we;
      unique case (state_q)
         IDLE: begin
            // Gate with reset so ready stays low while held in reset.
            if (any_req && i_cpu_rst_n) begin
               o_req_ready = grant;
               ctl_d.we    = i_req_we[grant_idx];
               ctl_d.addr  = ARB_ADDR_W'(i_req_addr[grant_idx]);
               ctl_d.wdata = ARB_DATA_W'(i_req_wdata[grant_idx]);
               owner_d     = grant_idx;
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            if (i_ctl_ready) begin
               cnt_d   = '0;
               state_d = WAIT_RSP;
            end
         end
         WAIT_RSP: begin
            if (rd_done || wr_done) begin
               rsp_valid_d[owner_q] = 1'b1;
               rsp_rdata_d = rd_done ? i_ctl_rdata : '0;
               last_d      = owner_q;
               state_d     = IDLE;
            end else if (cnt_q == CNT_W'(TIMEOUT)) begin
               rsp_valid_d[owner_q] = 1'b1;
               rsp_err_d   = 1'b1;
               last_d      = owner_q;
               state_d     = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_cpu_ck or negedge i_cpu_rst_n) begin
      if (!i_cpu_rst_n) begin
         state_q     <= IDLE;
         last_q      <= PORT_W'(NUM_PORTS - 1);
         owner_q     <= '0;
         cnt_q       <= '0;
         ctl_q       <= '0;
         rsp_valid_q <= '0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         owner_q     <= owner_d;
         cnt_q       <= cnt_d;
         ctl_q       <= ctl_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign o_ctl_valid = (state_q == ISSUE);
   assign o_ctl_we    = ctl_q.we;
   assign o_ctl_addr  = ctl_q.addr[ADDR_W-1:0];
   assign o_ctl_wdata = ctl_q.wdata[DATA_W-1:0];
   assign o_rsp_valid = rsp_valid_q;
   assign o_rsp_err   = rsp_err_q;
   assign o_rsp_rdata = rsp_rdata_q;

`ifdef DDR3_ARB_PERF_CNT_EN
   logic [NUM_PORTS-1:0][PERF_CNT_W-1:0] grant_cnt_q, grant_cnt_d;

   always_comb begin
      grant_cnt_d = grant_cnt_q;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (o_req_ready[p] && (grant_cnt_q[p] != '1)) begin
            grant_cnt_d[p] = grant_cnt_q[p] + 1'b1;
         end
      end
   end

   always_ff @(posedge i_cpu_ck or negedge i_cpu_rst_n) begin
      if (!i_cpu_rst_n) begin
         grant_cnt_q <= '0;
      end else begin
         grant_cnt_q <= grant_cnt_d;
      end
   end

   assign o_grant_cnt = grant_cnt_q;
`endif

endmodule
